pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/dff.sv | 25 ++
 rtl/pipe_ctrl_sat_cnt16.sv | 36 +++
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared cpu constants for the pipeline controller     |
// | rev 1.0                                                              |
// +-----------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam int DRAIN_W = 2;
  localparam logic [DRAIN_W-1:0] DRAIN_CYCLES = 2'd3;
  localparam int STALL_W = 16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dff : W-bit register with write enable and synchronous reset to 0    |
// | rev 1.0                                                              |
// +-----------------------------------------------------------------------+
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_sat_cnt16.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sat_cnt16 : 16-bit counter that sticks at all-ones instead of wrapping|
// | rev 1.0                                                              |
// +-----------------------------------------------------------------------+
module sat_cnt16
  import pipe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  output logic [STALL_W-1:0] cnt
);

  logic [STALL_W-1:0] cnt_q;
  logic [STALL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {STALL_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  dff #(.W(STALL_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .wen (1'b1),
    .d   (cnt_d),
    .q   (cnt_q)
  );

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pipe_ctrl : stall/flush/halt controller for the 16-bit 5-stage core  |
// | rev 1.0                                                              |
// +-----------------------------------------------------------------------+
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_stall,
  input  logic        imem_stall,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        halt_id,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        idex_we,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  state_e             state_q;
  state_e             state_d;
  logic [1:0]         state_raw_q;
  logic [DRAIN_W-1:0] drain_q;
  logic [DRAIN_W-1:0] drain_d;
  logic               stall_inc;

  dff #(.W(2)) u_state (
    .clk (clk),
    .rst (rst),
    .wen (1'b1),
    .d   (state_d),
    .q   (state_raw_q)
  );

  dff #(.W(DRAIN_W)) u_drain (
    .clk (clk),
    .rst (rst),
    .wen (1'b1),
    .d   (drain_d),
    .q   (drain_q)
  );

  assign state_q = state_e'(state_raw_q);

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    exmem_we   = 1'b1;
    memwb_we   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    state_d    = state_q;
    drain_d    = drain_q;
    stall_inc  = 1'b0;

    if (rst) begin
      // Bubble both front stages while the core is held in reset.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dmem_stall) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
            stall_inc = 1'b1;
          end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
          end else if (imem_stall) begin
            pc_we      = 1'b0;
            ifid_flush = 1'b1;
            stall_inc  = 1'b1;
          end else if (halt_id) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            state_d    = ST_DRAIN;
            drain_d    = DRAIN_CYCLES;
          end
        end
        ST_DRAIN: begin
          if (dmem_stall) begin
            {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
          end else begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
            drain_d    = drain_q - 1'b1;
            if (drain_q == 2'd1) begin
              state_d = ST_HALTED;
            end
          end
        end
        ST_HALTED: begin
          {pc_we, ifid_we, idex_we, exmem_we, memwb_we} = '0;
          halted = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
          drain_d = '0;
        end
      endcase
    end
  end

  sat_cnt16 u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

endmodule
`default_nettype wire
